// File: rtl/game_sprite_engine.sv
// One sprite: holds position/velocity, steps it once per frame, retires it when
// it leaves the screen, and drives a registered pixel enable/colour to the mixer.
module game_sprite_engine #(
  parameter int          X_WIDTH       = 10,
  parameter int          Y_WIDTH       = 10,
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          D_WIDTH       = 4,
  parameter logic [2:0]  SPRITE_RGB    = 3'b111,
  parameter logic [63:0] SPRITE_BITMAP = 64'hFF81_8181_8181_81FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               display_on,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               start,
  input  logic               stop,
  input  logic               update_en,
  input  logic [X_WIDTH-1:0] start_x,
  input  logic [Y_WIDTH-1:0] start_y,
  input  logic [D_WIDTH-1:0] start_dx,
  input  logic [D_WIDTH-1:0] start_dy,
  output logic [X_WIDTH-1:0] sprite_x,
  output logic [Y_WIDTH-1:0] sprite_y,
  output logic               active,
  output logic               off_screen,
  output logic               sprite_en,
  output logic [2:0]         sprite_rgb
);

  localparam logic [0:0] STATE_HIDDEN = 1'b0;
  localparam logic [0:0] STATE_ACTIVE = 1'b1;

  logic [0:0]         state;
  logic [D_WIDTH-1:0] dx;
  logic [D_WIDTH-1:0] dy;
  logic               moved;

  logic               frame_tick;
  logic [X_WIDTH-1:0] dx_ext;
  logic [Y_WIDTH-1:0] dy_ext;
  logic               beyond_edge;

  assign active = (state == STATE_ACTIVE);

  // x advances every clock, so this matches for exactly one cycle per frame.
  assign frame_tick  = (x == '0) && (y == Y_WIDTH'(SCREEN_HEIGHT));
  assign dx_ext      = {{(X_WIDTH-D_WIDTH){dx[D_WIDTH-1]}}, dx};
  assign dy_ext      = {{(Y_WIDTH-D_WIDTH){dy[D_WIDTH-1]}}, dy};
  // Underflow past 0 wraps to a large value, so one compare covers all four edges.
  assign beyond_edge = (sprite_x >= X_WIDTH'(SCREEN_WIDTH)) ||
                       (sprite_y >= Y_WIDTH'(SCREEN_HEIGHT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STATE_HIDDEN;
      sprite_x   <= '0;
      sprite_y   <= '0;
      dx         <= '0;
      dy         <= '0;
      moved      <= 1'b0;
      off_screen <= 1'b0;
    end else begin
      off_screen <= 1'b0;
      moved      <= 1'b0;
      if (start) begin
        state    <= STATE_ACTIVE;
        sprite_x <= start_x;
        sprite_y <= start_y;
        dx       <= start_dx;
        dy       <= start_dy;
      end else if (stop) begin
        state <= STATE_HIDDEN;
      end else if (moved && active && beyond_edge) begin
        state      <= STATE_HIDDEN;
        off_screen <= 1'b1;
      end else if (frame_tick && active && update_en) begin
        sprite_x <= sprite_x + dx_ext;
        sprite_y <= sprite_y + dy_ext;
        moved    <= 1'b1;
      end
    end
  end

  logic [X_WIDTH-1:0] col;
  logic [Y_WIDTH-1:0] row;
  logic [5:0]         pix_idx;
  logic               hit;

  assign col     = x - sprite_x;
  assign row     = y - sprite_y;
  // Row 0 lives in the top byte with column 0 as its MSB: index 63 - (row*8 + col).
  assign pix_idx = ~{row[2:0], col[2:0]};
  assign hit     = active && display_on &&
                   (col < X_WIDTH'(8)) && (row < Y_WIDTH'(8)) &&
                   SPRITE_BITMAP[pix_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_en  <= 1'b0;
      sprite_rgb <= 3'b000;
    end else begin
      sprite_en  <= hit;
      sprite_rgb <= hit ? SPRITE_RGB : 3'b000;
    end
  end

endmodule

// File: doc/game_sprite_engine.md
# game_sprite_engine

Per-sprite engine sitting between `game_hvsync` and `game_mixer`. It holds one sprite's position and velocity, steps the position once per frame, and retires the sprite when it leaves the screen. It compares the beam position against an 8×8 monochrome bitmap and produces the registered `sprite_*_en` / `sprite_*_rgb` pair the mixer consumes. Instantiated once per sprite (target, torpedo).

## Interface

Parameters:
- `X_WIDTH`, 10, beam and sprite X width in bits.
- `Y_WIDTH`, 10, beam and sprite Y width in bits.
- `SCREEN_WIDTH`, 640, visible width.
- `SCREEN_HEIGHT`, 480, visible height.
- `D_WIDTH`, 4, width of signed per-frame velocity.
- `SPRITE_RGB`, 3'b111, colour of set bitmap pixels.
- `SPRITE_BITMAP`, 64'hFF81_8181_8181_81FF, 8×8 bitmap, row 0 in bits [63:56], column 0 = MSB of each row.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; one clock, reset is synchronous and active-high.
- `display_on`  in  1  from hvsync, beam in visible area.
- `x`  in  X_WIDTH  beam X from hvsync.
- `y`  in  Y_WIDTH  beam Y from hvsync.
- `start`  in  1  pulse: load `start_x/start_y/start_dx/start_dy`, activate.
- `stop`  in  1  pulse: deactivate sprite.
- `update_en`  in  1  level: allow motion at frame ticks.
- `start_x`  in  X_WIDTH  initial X (top-left).
- `start_y`  in  Y_WIDTH  initial Y (top-left).
- `start_dx`  in  D_WIDTH  signed X step per frame.
- `start_dy`  in  D_WIDTH  signed Y step per frame.
- `sprite_x`  out  X_WIDTH  current X.
- `sprite_y`  out  Y_WIDTH  current Y.
- `active`  out  1  sprite in ACTIVE state.
- `off_screen`  out  1  one-cycle pulse when auto-retired.
- `sprite_en`  out  1  pixel of this sprite at beam (to mixer).
- `sprite_rgb`  out  3  pixel colour (to mixer).

## Operation

- States: HIDDEN (reset state), ACTIVE.
- HIDDEN → ACTIVE on `start`. Loads `sprite_x/sprite_y` and dx/dy registers from the `start_*` ports.
- ACTIVE → ACTIVE on `start` (reload, restart).
- ACTIVE → HIDDEN on `stop`, or on auto-retire.
- Priority: `start` > `stop` > frame-tick motion.
- Frame tick is `x == 0 && y == SCREEN_HEIGHT`, the first blanking line; hvsync counts Y into blanking. The tick is a single cycle because x advances every clock.
- On tick, in ACTIVE with `update_en`=1:
  - `sprite_x <= sprite_x + sext(dx)`, `sprite_y <= sprite_y + sext(dy)`.
  - Modulo 2^X_WIDTH / 2^Y_WIDTH; no saturation.
- Auto-retire: in the cycle after an update, if `sprite_x >= SCREEN_WIDTH || sprite_y >= SCREEN_HEIGHT`, go to HIDDEN and pulse `off_screen` for 1 cycle.
  - Moving left or up past 0 wraps to a large value and counts as off-screen.
  - A `start` in that cycle wins: reload, no pulse.
- Position and velocity hold their values in HIDDEN.
- Hit detection:
  - `col = x - sprite_x`, `row = y - sprite_y`, unsigned, truncated to the port widths.
  - Hit when `active && display_on && col < 8 && row < 8`.
  - Pixel bit = `SPRITE_BITMAP[63 - (row*8 + col)]`.
- Right and bottom edges clip naturally, because `display_on` is low outside the visible area.

## Timing

- Reset values: state HIDDEN, `sprite_x`=0, `sprite_y`=0, dx=dy=0, `active`=0, `off_screen`=0, `sprite_en`=0, `sprite_rgb`=0.
- `sprite_en` and `sprite_rgb` are registered, with 1-cycle latency from `x/y/display_on`.
- `sprite_rgb` = `SPRITE_RGB` when the registered enable is set, else 0.
- `start` takes effect at the next edge: `active`=1 and position loaded one cycle after the pulse. Pixel output can appear from the following cycle.
- `stop` drops `active` next cycle. `sprite_en` is 0 from the cycle after that.
- Motion occurs only at a tick, so position is stable throughout every visible frame.
- Reset mid-frame or mid-motion overrides everything at the next edge.

## Test plan

- Reset: hold reset 3 cycles, then sweep a frame → all outputs 0, `active`=0, `sprite_en` never 1.
- Draw: `start` with (100,50), d=(0,0), `update_en`=0; beam at (100,50) → `sprite_en`=1, `sprite_rgb`=3'b111 one cycle later. Beam at (103,53) (bitmap 0) → `sprite_en`=0. Beam at (108,50) → 0.
- Motion: d=(+3,−2), `update_en`=1, 4 frame ticks → `sprite_x`=112, `sprite_y`=42. No change between ticks. With `update_en`=0 the position is held.
- Off-screen: start (636,10), dx=+4 → after one tick `sprite_x`=640, `off_screen` pulses 1 cycle, `active`=0. Repeat with start (1,10), dx=−2 → wraps to 1023 and retires the same way.
- Priority: `start` and `stop` asserted together → ACTIVE with new position. `start` on the retire cycle → reload, no `off_screen` pulse. `stop` on a tick → HIDDEN, position not updated.
- Clipping: start (636,476) → pixels drawn only at x≤639, y≤479. No `sprite_en` during blanking.
